// File: rtl/scan_frame_processor.sv
// Streaming rangefinder frame processor: min/max distance, near-hit vector and
// interpolated angles. Define SCAN_ANGLE_EN to build the angle dividers and CALC state.
module scan_frame_processor #(
    parameter int DIST_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int HIT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         datain,
    input  logic               flashin,
    input  logic [DIST_W-1:0]  hit_thresh,
    output logic               busy,
    output logic [DIST_W-1:0]  lowest,
    output logic [DIST_W-1:0]  highest,
    output logic [ANGLE_W-1:0] lowest_angle,
    output logic [ANGLE_W-1:0] highest_angle,
    output logic [HIT_W-1:0]   hitvector,
    output logic               frame_err,
    output logic               flashout
);
    // state   | meaning
    // IDLE    | waiting for the length byte
    // FSA_RX  | assembling first scan angle
    // LSA_RX  | assembling last scan angle
    // DATA_RX | assembling samples, updating stats
    // CALC    | interpolating angles (dividers)
    // DONE    | flashout pulse, back to IDLE
    typedef enum logic [2:0] {IDLE, FSA_RX, LSA_RX, DATA_RX, CALC, DONE} state_t;

    localparam logic [7:0] DIST_LAST  = 8'(DIST_W / 8 - 1);
    localparam logic [7:0] ANGLE_LAST = 8'(ANGLE_W / 8 - 1);

    state_t              state;
    logic [7:0]          n_len, byte_cnt, sample_idx;
    logic [DIST_W-1:0]   thresh, dist_acc, sample;
    logic [DIST_W+7:0]   dist_wide;
    logic [HIT_W-1:0]    hit_mask;

    // Bytes arrive LSB first: shift right, new byte enters at the top.
    assign dist_wide = {datain, dist_acc};
    assign sample    = dist_wide[DIST_W+7:8];
    assign hit_mask  = HIT_W'(1) << sample_idx;

`ifdef SCAN_ANGLE_EN
    localparam int QW = ANGLE_W + 9;
    localparam int CW = $clog2(QW + 1);

    logic [ANGLE_W-1:0]  fsa, lsa;
    logic [ANGLE_W+7:0]  fsa_wide, lsa_wide;
    logic [7:0]          lo_idx, hi_idx, divisor, lo_r, hi_r;
    logic [CW-1:0]       calc_cnt;
    logic                calc_first;
    logic [QW-1:0]       fsa_x, lsa_x, lo_div, hi_div, lo_q, hi_q;
    logic [QW+7:0]       lo_step, hi_step;

    // One restoring step: returns {quotient shift reg, remainder}.
    function automatic logic [QW+7:0] div_step(input logic [QW-1:0] q,
                                               input logic [7:0]    r,
                                               input logic [7:0]    d);
        logic [8:0] rs;
        rs = {r, q[QW-1]};
        if (rs >= {1'b0, d})
            div_step = {q[QW-2:0], 1'b1, 8'(rs - {1'b0, d})};
        else
            div_step = {q[QW-2:0], 1'b0, rs[7:0]};
    endfunction

    assign fsa_wide   = {datain, fsa};
    assign lsa_wide   = {datain, lsa};
    assign divisor    = n_len - 8'd1;
    assign fsa_x      = QW'(fsa);
    assign lsa_x      = QW'(lsa);
    assign lo_div     = fsa_x * QW'(divisor - lo_idx) + lsa_x * QW'(lo_idx);
    assign hi_div     = fsa_x * QW'(divisor - hi_idx) + lsa_x * QW'(hi_idx);
    assign calc_first = (calc_cnt == '0);
    assign lo_step    = div_step(calc_first ? lo_div : lo_q, calc_first ? 8'd0 : lo_r, divisor);
    assign hi_step    = div_step(calc_first ? hi_div : hi_q, calc_first ? 8'd0 : hi_r, divisor);
`else
    assign lowest_angle  = '0;
    assign highest_angle = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            n_len      <= '0;
            byte_cnt   <= '0;
            sample_idx <= '0;
            thresh     <= '0;
            dist_acc   <= '0;
            busy       <= 1'b0;
            lowest     <= '0;
            highest    <= '0;
            hitvector  <= '0;
            frame_err  <= 1'b0;
            flashout   <= 1'b0;
`ifdef SCAN_ANGLE_EN
            fsa           <= '0;
            lsa           <= '0;
            lo_idx        <= '0;
            hi_idx        <= '0;
            calc_cnt      <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            lo_r          <= '0;
            hi_r          <= '0;
            lowest_angle  <= '0;
            highest_angle <= '0;
`endif
        end else begin
            flashout <= 1'b0;
            case (state)
                IDLE: if (flashin) begin
                    n_len      <= datain;
                    thresh     <= hit_thresh;
                    byte_cnt   <= '0;
                    sample_idx <= '0;
                    lowest     <= '0;
                    highest    <= '0;
                    hitvector  <= '0;
`ifdef SCAN_ANGLE_EN
                    lowest_angle  <= '0;
                    highest_angle <= '0;
                    lo_idx        <= '0;
                    hi_idx        <= '0;
`endif
                    if (datain == 8'd0) begin
                        frame_err <= 1'b1;
                        flashout  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        frame_err <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FSA_RX;
                    end
                end
                FSA_RX: if (flashin) begin
`ifdef SCAN_ANGLE_EN
                    fsa <= fsa_wide[ANGLE_W+7:8];
`endif
                    if (byte_cnt == ANGLE_LAST) begin
                        byte_cnt <= '0;
                        state    <= LSA_RX;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                LSA_RX: if (flashin) begin
`ifdef SCAN_ANGLE_EN
                    lsa <= lsa_wide[ANGLE_W+7:8];
`endif
                    if (byte_cnt == ANGLE_LAST) begin
                        byte_cnt <= '0;
                        state    <= DATA_RX;
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                DATA_RX: if (flashin) begin
                    dist_acc <= sample;
                    if (byte_cnt == DIST_LAST) begin
                        byte_cnt   <= '0;
                        sample_idx <= sample_idx + 8'd1;
                        if (sample < thresh)
                            hitvector <= hitvector | hit_mask;
                        // Strict compares: ties keep the earliest index.
                        if (sample_idx == 8'd0) begin
                            lowest  <= sample;
                            highest <= sample;
                        end else begin
                            if (sample < lowest) begin
                                lowest <= sample;
`ifdef SCAN_ANGLE_EN
                                lo_idx <= sample_idx;
`endif
                            end
                            if (sample > highest) begin
                                highest <= sample;
`ifdef SCAN_ANGLE_EN
                                hi_idx  <= sample_idx;
`endif
                            end
                        end
                        if (sample_idx == n_len - 8'd1) begin
`ifdef SCAN_ANGLE_EN
                            calc_cnt <= '0;
                            state    <= CALC;
`else
                            flashout <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
`endif
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                CALC: begin
`ifdef SCAN_ANGLE_EN
                    if (n_len == 8'd1) begin
                        lowest_angle  <= fsa;
                        highest_angle <= fsa;
                        flashout      <= 1'b1;
                        busy          <= 1'b0;
                        state         <= DONE;
                    end else begin
                        {lo_q, lo_r} <= lo_step;
                        {hi_q, hi_r} <= hi_step;
                        calc_cnt     <= calc_cnt + CW'(1);
                        if (calc_cnt == CW'(QW - 1)) begin
                            lowest_angle  <= lo_step[ANGLE_W+7:8];
                            highest_angle <= hi_step[ANGLE_W+7:8];
                            flashout      <= 1'b1;
                            busy          <= 1'b0;
                            state         <= DONE;
                        end
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_frame_processor.sv
// Table-driven scoreboard bench for scan_frame_processor (either SCAN_ANGLE_EN build).
module tb_scan_frame_processor;
    localparam int AW = 16;
`ifdef SCAN_ANGLE_EN
    localparam bit ANG_EN = 1'b1;
`else
    localparam bit ANG_EN = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b1, flashin = 1'b0;
    logic [7:0]  datain = 8'h00;
    logic [15:0] hit_thresh = 16'h0000;
    logic        busy, frame_err, flashout;
    logic [15:0] lowest, highest, lowest_angle, highest_angle, hitvector;

    always #5 clock = ~clock;

    scan_frame_processor dut (
        .clock(clock), .reset(reset), .datain(datain), .flashin(flashin),
        .hit_thresh(hit_thresh), .busy(busy), .lowest(lowest), .highest(highest),
        .lowest_angle(lowest_angle), .highest_angle(highest_angle),
        .hitvector(hitvector), .frame_err(frame_err), .flashout(flashout)
    );

    typedef struct packed {
        logic [7:0]        n;
        logic [15:0]       fsa, lsa, thresh;
        logic [19:0][15:0] s;
        logic              gap;
        logic [15:0]       lo, hi, lo_ang, hi_ang, hv;
        logic              ferr;
    } vec_t;

    typedef struct packed {
        logic [15:0] lo, hi, lo_ang, hi_ang, hv;
        logic        ferr;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[7];
    int   total = 0, bad = 0, n_flash = 0, cyc = 0, last_acc = 0, frames_sent = 0;
    logic mark = 1'b0, prev_flash = 1'b0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (flashin && mark) last_acc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (flashout === 1'b1) begin
            n_flash++;
            chk("flash_width", prev_flash, 1'b0);
            if (exp_q.size() == 0) begin
                chk("unexpected_flashout", flashout, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("lowest", lowest, e.lo);
                chk("highest", highest, e.hi);
                chk("lowest_angle", lowest_angle, e.lo_ang);
                chk("highest_angle", highest_angle, e.hi_ang);
                chk("hitvector", hitvector, e.hv);
                chk("frame_err", frame_err, e.ferr);
                chk("latency", cyc - last_acc + 1, e.lat);
            end
        end
        prev_flash = flashout;
    end

    function automatic vec_t mk(input logic [7:0] n, input logic [15:0] fsa, lsa, thr,
                                input logic gap, input logic [15:0] lo, hi, la, ha, hv,
                                input logic ferr);
        vec_t v;
        v = '0;
        v.n = n; v.fsa = fsa; v.lsa = lsa; v.thresh = thr; v.gap = gap;
        v.lo = lo; v.hi = hi; v.lo_ang = la; v.hi_ang = ha; v.hv = hv; v.ferr = ferr;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic gap, input logic mk_acc);
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clock);
        datain  = b;
        flashin = 1'b1;
        mark    = mk_acc;
        @(negedge clock);
        flashin = 1'b0;
        mark    = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        e.lo     = v.lo;
        e.hi     = v.hi;
        e.lo_ang = ANG_EN ? v.lo_ang : 16'h0;
        e.hi_ang = ANG_EN ? v.hi_ang : 16'h0;
        e.hv     = v.hv;
        e.ferr   = v.ferr;
        e.lat    = (v.n == 0 || !ANG_EN) ? 1 : (v.n == 1) ? 2 : AW + 10;
        exp_q.push_back(e);
        frames_sent++;
        hit_thresh = v.thresh;
        send_byte(v.n, v.gap, 1'b1);
        hit_thresh = 16'($urandom);
        if (v.n != 0) begin
            chk("busy_mid", busy, 1'b1);
            send_byte(v.fsa[7:0], v.gap, 1'b1);
            send_byte(v.fsa[15:8], v.gap, 1'b1);
            send_byte(v.lsa[7:0], v.gap, 1'b1);
            send_byte(v.lsa[15:8], v.gap, 1'b1);
            for (int k = 0; k < int'(v.n); k++) begin
                send_byte(v.s[k][7:0], v.gap, 1'b1);
                send_byte(v.s[k][15:8], v.gap, 1'b1);
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("done_timeout", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        int saved;
        vecs[0] = mk(3, 16'h0000, 16'h00C8, 16'h0400, 0, 16'h0100, 16'h0900, 16'h0064, 16'h00C8, 16'h0002, 0);
        vecs[0].s[0] = 16'h0500; vecs[0].s[1] = 16'h0100; vecs[0].s[2] = 16'h0900;
        vecs[1] = mk(1, 16'h1234, 16'h5678, 16'h0400, 0, 16'h0300, 16'h0300, 16'h1234, 16'h1234, 16'h0001, 0);
        vecs[1].s[0] = 16'h0300;
        vecs[2] = mk(2, 16'h0010, 16'h0020, 16'h0100, 1, 16'h0200, 16'h0200, 16'h0010, 16'h0010, 16'h0000, 0);
        vecs[2].s[0] = 16'h0200; vecs[2].s[1] = 16'h0200;
        vecs[3] = mk(0, 16'h0000, 16'h0000, 16'h7777, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
        vecs[4] = mk(4, 16'h0064, 16'h0000, 16'h0800, 0, 16'h0050, 16'h0A00, 16'h0000, 16'h0021, 16'h000A, 0);
        vecs[4].s[0] = 16'h0800; vecs[4].s[1] = 16'h0700; vecs[4].s[2] = 16'h0A00; vecs[4].s[3] = 16'h0050;
        vecs[5] = mk(20, 16'h0100, 16'h0300, 16'h0100, 0, 16'h0010, 16'hFFFF, 16'h0100, 16'h0300, 16'hFFFF, 0);
        for (int k = 0; k < 19; k++) vecs[5].s[k] = 16'h0010;
        vecs[5].s[19] = 16'hFFFF;
        vecs[6] = mk(5, 16'hFFFF, 16'h0001, 16'hFFFF, 0, 16'h0001, 16'hFFFF, 16'hBFFF, 16'hFFFF, 16'h001E, 0);
        vecs[6].s[0] = 16'hFFFF; vecs[6].s[1] = 16'h0001; vecs[6].s[2] = 16'h0001;
        vecs[6].s[3] = 16'h8000; vecs[6].s[4] = 16'h0002;

        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lowest", lowest, 16'h0);
        chk("rst_highest", highest, 16'h0);
        chk("rst_lowest_angle", lowest_angle, 16'h0);
        chk("rst_highest_angle", highest_angle, 16'h0);
        chk("rst_hitvector", hitvector, 16'h0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_flashout", flashout, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i]);
            wait_done();
        end

        repeat (5) @(negedge clock);
        chk("hold_lowest", lowest, vecs[6].lo);
        chk("hold_hitvector", hitvector, vecs[6].hv);
        chk("idle_busy", busy, 1'b0);

`ifdef SCAN_ANGLE_EN
        send_frame(vecs[4]);
        repeat (3) @(negedge clock);
        send_byte(8'h05, 1'b0, 1'b0);
        wait_done();
`endif

        hit_thresh = 16'hFFFF;
        send_byte(8'd3, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        chk("partial_lowest", lowest, 16'h1234);
        reset   = 1'b1;
        datain  = 8'h00;
        flashin = 1'b1;
        @(negedge clock);
        chk("midrst_lowest", lowest, 16'h0);
        chk("midrst_hitvector", hitvector, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_flashout", flashout, 1'b0);
        flashin = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        saved = n_flash;
        repeat (40) @(negedge clock);
        chk("aborted_no_flash", n_flash, saved);

        send_frame(vecs[0]);
        wait_done();
        chk("flash_count", n_flash, frames_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
